serial_tx: RTL and testbench

//  Framed serial transmitter (UART-style, 8N1 by default): the sending end of
//  the single-wire serial link whose receiver samples the line with D flops.

---
 rtl/serial_tx_pkg.sv | 29 ++
 rtl/serial_tx_if.sv | 30 +++
 rtl/serial_tx_bit_timer.sv | 39 +++
 rtl/serial_tx.sv | 131 +++++++++++++
 tb/tb_serial_tx.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_pkg
//  Purpose  : Shared state encodings, line levels and sizing helper for the
//             framed serial transmitter and its matching receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_tx_pkg;

   // Frame sequencer states; encodings are shared with the receiver side.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Serial line levels.
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : serial_tx_pkg
`default_nettype wire

// File: rtl/serial_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_if
//  Purpose  : Parallel word handshake plus serial line and status signals
//             between a producer and the serial transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             in_valid;
   logic             in_ready;
   logic             tx;
   logic             busy;
   logic             done;

   // Producer side: offers words, observes line and status.
   modport master (
      output data_in, in_valid,
      input  in_ready, tx, busy, done
   );

   // Transmitter side.
   modport slave (
      input  data_in, in_valid,
      output in_ready, tx, busy, done
   );
endinterface : serial_tx_if
`default_nettype wire

// File: rtl/serial_tx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bit_timer
//  Purpose  : Bit-period timer. Counts 0..CLKS_PER_BIT-1, pulses tick on the
//             last clock of each period and restarts from zero on clear.
//  Revision : 1.0 - initial release
// ============================================================================
module bit_timer
   import serial_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  wire logic clk,
   input  wire logic reset,   // asynchronous, active low
   input  wire logic clear,
   output logic      tick
);

   localparam int                CNT_W  = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;

   // With a one-clock bit period the counter sits at zero and tick is constant.
   assign tick = (r_count == c_LAST);

   // Period counter: hold at zero while cleared, wrap after the last clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clear || tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule : bit_timer
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx
//  Purpose  : Framed serial transmitter (8N1 by default). Accepts a parallel
//             word on a valid/ready handshake and shifts it out LSB-first
//             between a start bit and a stop bit, each bit held for
//             CLKS_PER_BIT clocks. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  wire logic   clk,
   input  wire logic   reset,   // asynchronous, active low
   serial_tx_if.slave  bus
);

   localparam int               IDX_W      = cnt_width(WIDTH);
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_next;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_next;
   logic             r_tx;
   logic             w_tx_next;
   logic             r_busy;
   logic             r_ready;
   logic             r_done;
   logic             w_done_next;
   logic             w_tick;
   logic             w_timer_clear;

   // The timer runs only while a frame is on the line, so each frame starts
   // with a full-length start bit.
   assign w_timer_clear = (r_state == IDLE);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk   (clk),
      .reset (reset),
      .clear (w_timer_clear),
      .tick  (w_tick)
   );

   assign bus.tx       = r_tx;
   assign bus.busy     = r_busy;
   assign bus.in_ready = r_ready;
   assign bus.done     = r_done;

   // Next-state, datapath and next-output logic; outputs follow the next state
   // so the registered line level is correct in the first cycle of each state.
   always_comb begin
      w_state_next = r_state;
      w_shift_next = r_shift;
      w_idx_next   = r_idx;
      w_done_next  = 1'b0;
      w_tx_next    = LINE_IDLE;

      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_state_next = START;
               w_shift_next = bus.data_in;
               w_idx_next   = '0;
            end
         end
         START: begin
            if (w_tick) begin
               w_state_next = DATA;
               w_idx_next   = '0;
            end
         end
         DATA: begin
            if (w_tick) begin
               w_shift_next = r_shift >> 1;
               if (r_idx == c_LAST_IDX) begin
                  w_state_next = STOP;
               end else begin
                  w_idx_next = r_idx + IDX_W'(1);
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               w_state_next = IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      case (w_state_next)
         START:   w_tx_next = START_BIT;
         DATA:    w_tx_next = w_shift_next[0];
         STOP:    w_tx_next = STOP_BIT;
         default: w_tx_next = LINE_IDLE;
      endcase
   end

   // State, datapath and output registers; reset aborts any frame at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_tx    <= LINE_IDLE;
         r_busy  <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_shift <= w_shift_next;
         r_idx   <= w_idx_next;
         r_tx    <= w_tx_next;
         r_busy  <= (w_state_next != IDLE);
         r_ready <= (w_state_next == IDLE);
         r_done  <= w_done_next;
      end
   end

endmodule : serial_tx
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx
//  Purpose  : Directed self-checking bench for serial_tx with a 4-clock and a
//             1-clock bit period instance sharing clock and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   serial_tx_if #(.WIDTH(8)) bus0 ();
   serial_tx_if #(.WIDTH(8)) bus1 ();

   serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed status packed as {tx, busy, in_ready, done}.
   function automatic logic [3:0] obs(input int sel);
      if (sel == 0) return {bus0.tx, bus0.busy, bus0.in_ready, bus0.done};
      return {bus1.tx, bus1.busy, bus1.in_ready, bus1.done};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Called at the negedge of frame clock 1; checks every clock of the frame
   // and returns at the negedge of the done cycle after checking it.
   task automatic check_frame(input int sel, input string name,
                              input logic [9:0] f, input int cpb);
      for (int b = 0; b < 10; b++) begin
         for (int k = 0; k < cpb; k++) begin
            check($sformatf("%s bit%0d clk%0d", name, b, k), obs(sel),
                  {f[b], 1'b1, 1'b0, 1'b0});
            @(negedge clk);
         end
      end
      check($sformatf("%s done", name), obs(sel), 4'b1011);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      bus0.data_in  = 8'hAA;
      bus0.in_valid = 1'b1;
      bus1.data_in  = 8'h00;
      bus1.in_valid = 1'b0;

      // 1: reset held with in_valid high -> idle outputs, no accept
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset cyc%0d", i), obs(0), 4'b1010);
      end
      check("reset dut1", obs(1), 4'b1010);
      bus0.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("post reset idle", obs(0), 4'b1010);

      // 2: single frame A5 -> 0,1,0,1,0,0,1,0,1,1
      bus0.data_in  = 8'hA5;
      bus0.in_valid = 1'b1;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      check_frame(0, "A5", 10'b11_0100_1010, 4);
      @(negedge clk);
      check("A5 after done", obs(0), 4'b1010);

      // 3: back-to-back 00 then FF with in_valid held high
      bus0.data_in  = 8'h00;
      bus0.in_valid = 1'b1;
      @(negedge clk);
      bus0.data_in  = 8'hFF;
      check_frame(0, "b2b00", 10'b10_0000_0000, 4);
      @(negedge clk);
      bus0.in_valid = 1'b0;
      check_frame(0, "b2bFF", 10'b11_1111_1110, 4);
      @(negedge clk);
      check("FF after done", obs(0), 4'b1010);

      // 4: data_in changed after accept is ignored (C3 -> 1,1,0,0,0,0,1,1)
      bus0.data_in  = 8'hC3;
      bus0.in_valid = 1'b1;
      @(negedge clk);
      bus0.data_in  = 8'h3C;
      bus0.in_valid = 1'b0;
      check_frame(0, "C3", 10'b11_1000_0110, 4);
      @(negedge clk);

      // 5: reset during data bit 3 of 55, then 0F sent cleanly
      bus0.data_in  = 8'h55;
      bus0.in_valid = 1'b1;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      repeat (17) @(negedge clk);     // frame clock 18: data bit 3
      check("55 d3 level", obs(0), 4'b0100);
      #2 reset = 1'b0;
      #1 check("abort async", obs(0), 4'b1010);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("abort hold%0d", i), obs(0), 4'b1010);
      end
      reset = 1'b1;
      @(negedge clk);
      check("abort release", obs(0), 4'b1010);
      bus0.data_in  = 8'h0F;
      bus0.in_valid = 1'b1;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      check_frame(0, "0F", 10'b10_0001_1110, 4);

      // 6: one-clock bit period, 81 -> 0,1,0,0,0,0,0,0,1,1, done on clock 11
      @(negedge clk);
      bus1.data_in  = 8'h81;
      bus1.in_valid = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      check_frame(1, "81x1", 10'b11_0000_0010, 1);
      @(negedge clk);
      check("81x1 after done", obs(1), 4'b1010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_serial_tx
`default_nettype wire
